program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
Boot-time controller that fills program memory from a byte stream, such as a UART receiver or debug link. It holds the core in reset while loading, assembles little-endian 32-bit words, drives the program-memory write port, and verifies a trailing 8-bit checksum. It sits between the external byte source and the program memory write port, and its cpu_hold output feeds the core's reset.

Parameters:
PC_WIDTH, 8, program-memory byte-address width; capacity = 2^(PC_WIDTH-2) words
OPD_WIDTH, 32, instruction word width; fixed at 32 (4 bytes per word)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle load request; sampled only in IDLE
len_words  input  PC_WIDTH-1  number of words to load; sampled with start
byte_valid  input  1  byte source has data
byte_data  input  8  byte payload
byte_ready  output  1  loader accepts byte this cycle (transfer = byte_valid & byte_ready)
mem_w_en  output  1  program-memory write strobe, one cycle per word
mem_addr  output  PC_WIDTH  byte address, word aligned (low 2 bits always 0)
mem_wdata  output  OPD_WIDTH  assembled instruction word
cpu_hold  output  1  core held in reset while high
busy  output  1  state != IDLE
done  output  1  one-cycle completion pulse
err  output  1  checksum or length error; sticky until next accepted start

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0; byte/word counters, word buffer and sum cleared. A partially received word is discarded; memory words already written remain.
- Outputs are Moore-style, decoded from registered state/registers. mem_addr and mem_wdata are 0 whenever mem_w_en=0.
- IDLE: byte_ready=0, cpu_hold=0.
  - On start with len_words=0: go to DONE; err=0; no writes.
  - On start with len_words > 2^(PC_WIDTH-2): err=1; done=1 next cycle; stay IDLE; cpu_hold stays 0; no writes.
  - Otherwise: latch len; clear err, sum, byte_cnt and word_idx; go to RECV.
- RECV: byte_ready=1, cpu_hold=1.
  - Each transfer places byte_data into lane byte_cnt (byte 0 -> bits 7:0) and adds it to the 8-bit sum (mod 256).
  - On the 4th transfer, go to WRITE.
- WRITE (exactly 1 cycle): byte_ready=0, mem_w_en=1, mem_addr=word_idx<<2, mem_wdata=buffer.
  - If word_idx==len-1, go to CHECK; otherwise word_idx++, byte_cnt=0, back to RECV.
- CHECK: byte_ready=1.
  - On transfer: err = ((sum + byte_data) mod 256 != 0); go to DONE.
- DONE (1 cycle): done=1, cpu_hold=1, byte_ready=0; then IDLE, where cpu_hold drops.
- Timing:
  - start at cycle n -> byte_ready high at n+1.
  - 4th byte accepted at cycle m -> mem_w_en high at m+1.
  - Maximum throughput is 5 cycles per word.
- busy=1 in RECV, WRITE, CHECK and DONE.
- start while busy is ignored; len_words is ignored except with an accepted start.
- byte_valid during IDLE, WRITE or DONE: no transfer and no state change.
- byte_valid may drop for any number of cycles; there is no timeout.
- Addresses never wrap: word_idx stays below capacity by the length check.

Test Plan:
- Reset: assert rst mid-cycle -> all outputs 0 immediately; after release busy=0, byte_ready=0.
- Nominal load: len_words=2; bytes 78 56 34 12 EF BE AD DE, checksum B4 ->
  - mem_w_en pulses with addr 0x00/data 0x12345678 and addr 0x04/data 0xDEADBEEF.
  - done pulses once, err=0, cpu_hold high from start+1 through the done cycle.
- Bad checksum: same stream with checksum 00 -> identical writes; done pulses; err=1 and holds until next start.
- Backpressure: byte_valid toggled 1-0-1 with random gaps, and held high through WRITE -> byte_ready=0 in WRITE; no byte lost or duplicated; same writes as the nominal load.
- Length edges (PC_WIDTH=8):
  - len_words=0 -> done after 1 cycle, no writes, err=0.
  - len_words=65 -> err=1, done pulse, cpu_hold never high.
  - len_words=64 -> last write at addr 0xFC.
- Reset mid-load: len_words=2, assert rst after 6 bytes -> only the addr 0 write occurred; cpu_hold=0, state IDLE. A fresh start then loads normally.

Source files
------------

// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
//
// Boot-time controller that fills program memory from a byte stream (UART
// receiver, debug link, ...). While a load is in progress the core is held in
// reset through cpu_hold. Incoming bytes are packed little-endian into 32-bit
// words, each finished word is written to program memory in a single-cycle
// write strobe, and a trailing 8-bit checksum byte is verified: the modulo-256
// sum of all payload bytes plus the checksum byte must be zero.
//
// Parameters
//   PC_WIDTH   program-memory byte-address width; capacity = 2^(PC_WIDTH-2)
//              words
//   OPD_WIDTH  instruction word width; fixed at 32 (four bytes per word)
//
// Ports
//   clk         clock, all state updates on the rising edge
//   rst         asynchronous, active-high reset
//   start       one-cycle load request, sampled only while idle
//   len_words   number of words to load, sampled together with start
//   byte_valid  byte source has data
//   byte_data   byte payload
//   byte_ready  loader accepts a byte this cycle (transfer = valid & ready)
//   mem_w_en    program-memory write strobe, one cycle per word
//   mem_addr    word-aligned byte address (low two bits always 0)
//   mem_wdata   assembled instruction word
//   cpu_hold    core held in reset while high
//   busy        loader is not idle
//   done        one-cycle completion pulse
//   err         checksum or length error, sticky until the next accepted start
//
// All outputs are registered: every transition loads the output registers
// with the values belonging to the state being entered, so they are glitch
// free and change only on the clock edge (or immediately on reset).
// -----------------------------------------------------------------------------
module program_loader #(
  parameter int PC_WIDTH  = 8,
  parameter int OPD_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [PC_WIDTH-2:0]  len_words,
  input  logic                 byte_valid,
  input  logic [7:0]           byte_data,
  output logic                 byte_ready,
  output logic                 mem_w_en,
  output logic [PC_WIDTH-1:0]  mem_addr,
  output logic [OPD_WIDTH-1:0] mem_wdata,
  output logic                 cpu_hold,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WRITE,
    CHECK,
    DONE
  } state_t;

  // Largest legal len_words value (the full memory). It is representable in
  // the PC_WIDTH-1 bit length field, so one larger value can still be
  // requested and must be rejected.
  localparam logic [PC_WIDTH-2:0] CAPACITY = {1'b1, {(PC_WIDTH-2){1'b0}}};
  localparam logic [PC_WIDTH-2:0] LEN_ONE  = {{(PC_WIDTH-2){1'b0}}, 1'b1};

  state_t                state;
  logic [PC_WIDTH-2:0]   last_idx;   // index of the final word (len - 1)
  logic [PC_WIDTH-3:0]   word_idx;   // word currently being assembled
  logic [1:0]            byte_cnt;   // byte lane for the next transfer
  logic [OPD_WIDTH-1:0]  buffer;     // word under assembly
  logic [7:0]            sum;        // running modulo-256 sum of payload bytes

  logic                  xfer;
  logic [PC_WIDTH-2:0]   len_m1;
  logic [7:0]            sum_next;
  logic                  last_word;

  assign xfer      = byte_valid & byte_ready;
  assign len_m1    = len_words - LEN_ONE;
  assign sum_next  = sum + byte_data;
  assign last_word = ({1'b0, word_idx} == last_idx);

  // NOTE: every register in this block is assigned with <= so that all of
  // them update together from the values present before the clock edge;
  // a blocking assignment here would let later statements see the new value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_idx   <= '0;
      word_idx   <= '0;
      byte_cnt   <= '0;
      buffer     <= '0;
      sum        <= '0;
      byte_ready <= 1'b0;
      mem_w_en   <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_hold   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      // Single-cycle outputs fall back to zero unless the transition below
      // enters a state that drives them.
      mem_w_en  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      done      <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            if (len_words == '0) begin
              // Empty load: report completion without touching memory.
              state    <= DONE;
              err      <= 1'b0;
              done     <= 1'b1;
              cpu_hold <= 1'b1;
              busy     <= 1'b1;
            end else if (len_words > CAPACITY) begin
              // Rejected without ever holding the core or leaving idle.
              err  <= 1'b1;
              done <= 1'b1;
            end else begin
              state      <= RECV;
              last_idx   <= len_m1;
              word_idx   <= '0;
              byte_cnt   <= '0;
              buffer     <= '0;
              sum        <= '0;
              err        <= 1'b0;
              byte_ready <= 1'b1;
              cpu_hold   <= 1'b1;
              busy       <= 1'b1;
            end
          end
        end

        RECV: begin
          if (xfer) begin
            buffer[{byte_cnt, 3'b000} +: 8] <= byte_data;
            sum                             <= sum_next;
            // The two-bit counter wraps to lane 0 after the fourth byte.
            byte_cnt                        <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              // The top lane is not in buffer yet, so the write data is
              // built from the byte arriving now.
              state      <= WRITE;
              byte_ready <= 1'b0;
              mem_w_en   <= 1'b1;
              mem_addr   <= {word_idx, 2'b00};
              mem_wdata  <= {byte_data, buffer[23:0]};
            end
          end
        end

        WRITE: begin
          byte_ready <= 1'b1;
          byte_cnt   <= '0;
          if (last_word) begin
            state <= CHECK;
          end else begin
            state    <= RECV;
            word_idx <= word_idx + 1'b1;
          end
        end

        CHECK: begin
          if (xfer) begin
            state      <= DONE;
            byte_ready <= 1'b0;
            done       <= 1'b1;
            err        <= (sum_next != 8'h00);
          end
        end

        DONE: begin
          state    <= IDLE;
          cpu_hold <= 1'b0;
          busy     <= 1'b0;
        end

        default: begin
          state      <= IDLE;
          byte_ready <= 1'b0;
          cpu_hold   <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// -----------------------------------------------------------------------------
// tb_program_loader
//
// Directed and randomized loads for program_loader. Expected memory writes
// are derived from the byte stream itself (word i at byte address 4*i, bytes
// packed little-endian), and the expected error flag from the modulo-256 sum
// of the whole stream including the checksum byte. A passive monitor records
// every write and a few always-true relationships between the outputs.
// -----------------------------------------------------------------------------
module tb_program_loader;

  localparam int PC_WIDTH  = 8;
  localparam int OPD_WIDTH = 32;

  typedef logic [7:0] byte_q_t[$];

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [PC_WIDTH-2:0]  len_words;
  logic                 byte_valid;
  logic [7:0]           byte_data;
  logic                 byte_ready;
  logic                 mem_w_en;
  logic [PC_WIDTH-1:0]  mem_addr;
  logic [OPD_WIDTH-1:0] mem_wdata;
  logic                 cpu_hold;
  logic                 busy;
  logic                 done;
  logic                 err;

  int checks = 0;
  int errors = 0;

  // Monitor state
  logic [39:0] wr_q[$];
  int done_cnt  = 0;
  int hold_cnt  = 0;
  int bad_ready = 0;
  int bad_idle  = 0;
  int bad_hold  = 0;

  always #5 clk = ~clk;

  program_loader #(
    .PC_WIDTH (PC_WIDTH),
    .OPD_WIDTH(OPD_WIDTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len_words (len_words),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_ready(byte_ready),
    .mem_w_en  (mem_w_en),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always @(negedge clk) begin
    if (mem_w_en) wr_q.push_back({mem_addr, mem_wdata});
    if (done) done_cnt++;
    if (cpu_hold) hold_cnt++;
    if (mem_w_en && byte_ready) bad_ready++;
    if (!mem_w_en && (mem_addr != '0 || mem_wdata != '0)) bad_idle++;
    if (cpu_hold !== busy) bad_hold++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present one byte and keep it on the bus until the loader takes it.
  // Optional random idle gaps drop byte_valid with junk data in between.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int guard = 0;
    if (gaps) begin
      repeat ($urandom_range(0, 3)) begin
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
        @(negedge clk);
      end
    end
    byte_valid = 1'b1;
    byte_data  = b;
    while (byte_ready !== 1'b1 && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    if (byte_ready !== 1'b1) check("byte_accept_timeout", 64'(byte_ready), 64'd1);
    @(negedge clk);
  endtask

  // Full load of len words from stream (payload followed by checksum byte).
  task automatic run_load(input string tag, input int len, input byte_q_t stream,
                          input bit gaps, input bit poke);
    logic [39:0] exp_q[$];
    int          sum = 0;
    logic        exp_err;
    for (int i = 0; i < len; i++)
      exp_q.push_back({8'(i * 4), stream[4*i+3], stream[4*i+2], stream[4*i+1], stream[4*i]});
    foreach (stream[k]) sum += int'(stream[k]);
    exp_err = (sum % 256) != 0;

    wr_q.delete();
    done_cnt = 0;
    start     = 1'b1;
    len_words = (PC_WIDTH-1)'(len);
    @(negedge clk);
    start = 1'b0;
    check({tag, ":ready_after_start"}, 64'(byte_ready), 64'd1);
    check({tag, ":hold_after_start"}, 64'(cpu_hold), 64'd1);
    check({tag, ":err_cleared"}, 64'(err), 64'd0);

    if (poke) begin
      // A second request while busy must change nothing.
      start     = 1'b1;
      len_words = 7'd5;
      @(negedge clk);
      start = 1'b0;
    end

    foreach (stream[k]) send_byte(stream[k], gaps);
    byte_valid = 1'b0;

    check({tag, ":done_pulse"}, 64'(done), 64'd1);
    check({tag, ":hold_in_done"}, 64'(cpu_hold), 64'd1);
    check({tag, ":err"}, 64'(err), 64'(exp_err));
    @(negedge clk);
    check({tag, ":done_dropped"}, 64'(done), 64'd0);
    check({tag, ":idle_after"}, {62'd0, busy, cpu_hold}, 64'd0);
    check({tag, ":err_held"}, 64'(err), 64'(exp_err));
    check({tag, ":write_count"}, 64'(wr_q.size()), 64'(len));
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
      check($sformatf("%s:write%0d", tag, i), 64'(wr_q[i]), 64'(exp_q[i]));
    check({tag, ":done_count"}, 64'(done_cnt), 64'd1);
  endtask

  initial begin
    byte_q_t nominal;
    byte_q_t bad;
    byte_q_t s;
    int      n;
    int      sum;

    rst        = 1'b1;
    start      = 1'b0;
    len_words  = '0;
    byte_valid = 1'b0;
    byte_data  = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_ctrl", {58'd0, byte_ready, mem_w_en, cpu_hold, busy, done, err}, 64'd0);
    check("reset_addr", 64'(mem_addr), 64'd0);
    check("reset_data", 64'(mem_wdata), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_busy", 64'(busy), 64'd0);
    check("post_reset_ready", 64'(byte_ready), 64'd0);

    nominal = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hB4};
    bad     = nominal;
    bad[8]  = 8'h00;

    run_load("nominal", 2, nominal, 1'b0, 1'b0);
    run_load("bad_sum", 2, bad, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    check("err_sticky", 64'(err), 64'd1);

    // Zero-length load: straight to completion, clears the old error
    wr_q.delete();
    done_cnt  = 0;
    start     = 1'b1;
    len_words = 7'd0;
    @(negedge clk);
    start = 1'b0;
    check("len0:done", 64'(done), 64'd1);
    check("len0:busy", 64'(busy), 64'd1);
    check("len0:hold", 64'(cpu_hold), 64'd1);
    check("len0:err", 64'(err), 64'd0);
    @(negedge clk);
    check("len0:idle", {61'd0, done, busy, cpu_hold}, 64'd0);
    check("len0:writes", 64'(wr_q.size()), 64'd0);
    check("len0:done_count", 64'(done_cnt), 64'd1);

    // One word beyond capacity: rejected, core never held
    wr_q.delete();
    done_cnt  = 0;
    hold_cnt  = 0;
    start     = 1'b1;
    len_words = 7'd65;
    @(negedge clk);
    start = 1'b0;
    check("len65:done", 64'(done), 64'd1);
    check("len65:err", 64'(err), 64'd1);
    check("len65:busy", 64'(busy), 64'd0);
    check("len65:ready", 64'(byte_ready), 64'd0);
    repeat (3) @(negedge clk);
    check("len65:done_count", 64'(done_cnt), 64'd1);
    check("len65:err_held", 64'(err), 64'd1);
    check("len65:hold_never", 64'(hold_cnt), 64'd0);
    check("len65:writes", 64'(wr_q.size()), 64'd0);

    // Backpressure with random gaps plus an ignored start while busy
    run_load("backpressure", 2, nominal, 1'b1, 1'b1);

    // Full memory
    s.delete();
    sum = 0;
    for (int i = 0; i < 256; i++) begin
      s.push_back(8'($urandom));
      sum += int'(s[i]);
    end
    s.push_back(8'((256 - (sum % 256)) % 256));
    run_load("len64", 64, s, 1'b0, 1'b0);
    if (wr_q.size() == 64) check("len64:last_addr", 64'(wr_q[63][39:32]), 64'hFC);

    // Random loads, random checksums and pacing
    for (int t = 0; t < 4; t++) begin
      n = $urandom_range(1, 4);
      s.delete();
      sum = 0;
      for (int i = 0; i < n * 4; i++) begin
        s.push_back(8'($urandom));
        sum += int'(s[i]);
      end
      if ($urandom_range(0, 1) == 1) s.push_back(8'((256 - (sum % 256)) % 256));
      else s.push_back(8'($urandom));
      run_load($sformatf("rand%0d", t), n, s, 1'($urandom_range(0, 1)), 1'b0);
    end

    // Reset in the middle of the second word
    wr_q.delete();
    start     = 1'b1;
    len_words = 7'd2;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 6; k++) send_byte(nominal[k], 1'b0);
    byte_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("midrst_ctrl", {58'd0, byte_ready, mem_w_en, cpu_hold, busy, done, err}, 64'd0);
    check("midrst_addr", 64'(mem_addr), 64'd0);
    check("midrst_data", 64'(mem_wdata), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_idle", {61'd0, busy, byte_ready, cpu_hold}, 64'd0);
    check("midrst_writes", 64'(wr_q.size()), 64'd1);
    if (wr_q.size() >= 1) check("midrst_write0", 64'(wr_q[0]), {24'd0, 8'h00, 32'h12345678});

    run_load("after_reset", 2, nominal, 1'b0, 1'b0);

    check("ready_low_in_write", 64'(bad_ready), 64'd0);
    check("addr_data_zero_when_idle", 64'(bad_idle), 64'd0);
    check("hold_tracks_busy", 64'(bad_hold), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time limit so the run always ends on its own.
  initial begin
    #500000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
